// File: rtl/pb_ddr_mailbox_pkg.sv
// Shared definitions for the PicoBlaze DDR mailbox: register offsets,
// STATUS bit positions and the sequencer state encoding.
package pb_ddr_mailbox_pkg;

  localparam logic [3:0] REG_ADDR0    = 4'h0;
  localparam logic [3:0] REG_ADDR1    = 4'h1;
  localparam logic [3:0] REG_ADDR2    = 4'h2;
  localparam logic [3:0] REG_WDATA_LO = 4'h3;
  localparam logic [3:0] REG_WDATA_HI = 4'h4;
  localparam logic [3:0] REG_CMD      = 4'h5;
  localparam logic [3:0] REG_RDATA_LO = 4'h6;
  localparam logic [3:0] REG_RDATA_HI = 4'h7;
  localparam logic [3:0] REG_STATUS   = 4'h8;
  localparam logic [3:0] REG_IRQ_EN   = 4'h9;
  localparam logic [3:0] REG_CLEAR    = 4'hA;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_OVERRUN = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/pb_port_regs.sv
// KCPSM3 port-bus decode, host-writable mailbox registers and the
// registered in_port read mux.
module pb_port_regs
  import pb_ddr_mailbox_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'h00,
  parameter int         ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        port_id,
  input  logic              write_strobe,
  input  logic [7:0]        out_port,
  output logic [7:0]        in_port,
  input  logic [15:0]       rdata,
  input  logic [3:0]        status,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       wdata,
  output logic              irq_en,
  output logic              cmd_wr,
  output logic              cmd_we,
  output logic              clr_done,
  output logic              clr_timeout,
  output logic              clr_overrun
);

  logic       hit;
  logic [3:0] off;
  logic       wr_hit;
  logic [23:0] addr_ext;
  logic [7:0]  rd_mux;

  assign hit      = (port_id[7:4] == BASE_PORT[7:4]);
  assign off      = port_id[3:0];
  assign wr_hit   = write_strobe && hit;
  // zero-extended view so bytes above ADDR_W read back as 0
  assign addr_ext = 24'(addr);

  assign cmd_wr      = wr_hit && (off == REG_CMD);
  assign cmd_we      = out_port[0];
  assign clr_done    = wr_hit && (off == REG_CLEAR) && out_port[ST_DONE];
  assign clr_timeout = wr_hit && (off == REG_CLEAR) && out_port[ST_TIMEOUT];
  assign clr_overrun = wr_hit && (off == REG_CLEAR) && out_port[ST_OVERRUN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr   <= '0;
      wdata  <= '0;
      irq_en <= 1'b0;
    end else if (wr_hit) begin
      case (off)
        REG_ADDR0:    addr <= ADDR_W'({addr_ext[23:8], out_port});
        REG_ADDR1:    addr <= ADDR_W'({addr_ext[23:16], out_port, addr_ext[7:0]});
        REG_ADDR2:    addr <= ADDR_W'({out_port, addr_ext[15:0]});
        REG_WDATA_LO: wdata[7:0]  <= out_port;
        REG_WDATA_HI: wdata[15:8] <= out_port;
        REG_IRQ_EN:   irq_en <= out_port[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (hit) begin
      case (off)
        REG_ADDR0:    rd_mux = addr_ext[7:0];
        REG_ADDR1:    rd_mux = addr_ext[15:8];
        REG_ADDR2:    rd_mux = addr_ext[23:16];
        REG_WDATA_LO: rd_mux = wdata[7:0];
        REG_WDATA_HI: rd_mux = wdata[15:8];
        REG_RDATA_LO: rd_mux = rdata[7:0];
        REG_RDATA_HI: rd_mux = rdata[15:8];
        REG_STATUS:   rd_mux = {4'h0, status};
        REG_IRQ_EN:   rd_mux = {7'h00, irq_en};
        default:      rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_port <= 8'h00;
    else          in_port <= rd_mux;
  end

endmodule

// File: rtl/pb_ddr_mailbox.sv
// PicoBlaze command mailbox that runs one DDR word access per CMD write.
//   state     | meaning
//   S_IDLE    | waiting for a CMD write
//   S_REQ     | ddr_req held with stable shadows until ddr_ack
//   S_WAIT_RD | read accepted, waiting for ddr_rvalid
//   S_DONE    | one-cycle completion, raises done
module pb_ddr_mailbox
  import pb_ddr_mailbox_pkg::*;
#(
  parameter logic [7:0] BASE_PORT   = 8'h00,
  parameter int         ADDR_W      = 24,
  parameter int         DATA_W      = 16,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        port_id,
  input  logic              write_strobe,
  input  logic              read_strobe,
  input  logic [7:0]        out_port,
  output logic [7:0]        in_port,
  output logic              interrupt,
  input  logic              interrupt_ack,
  output logic              ddr_req,
  output logic              ddr_we,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [DATA_W-1:0] ddr_wdata,
  input  logic              ddr_ack,
  input  logic [DATA_W-1:0] ddr_rdata,
  input  logic              ddr_rvalid
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                done_q, timeout_q, overrun_q;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                irq_en, cmd_wr, cmd_we;
  logic                clr_done, clr_timeout, clr_overrun;
  logic                busy, tc;
  logic                req_d, load_shadow, cnt_load, cnt_dec, cap_rdata;
  logic                set_done, set_timeout, set_overrun;
  logic [3:0]          status;
  // every readable register is side-effect free, so read_strobe is not needed
  logic                unused_read_strobe;

  assign unused_read_strobe = read_strobe;
  assign busy   = (state_q == S_REQ) || (state_q == S_WAIT_RD);
  assign tc     = (cnt_q == CNT_W'(1));
  assign status = {overrun_q, timeout_q, done_q, busy};

  pb_port_regs #(.BASE_PORT(BASE_PORT), .ADDR_W(ADDR_W)) u_regs (
    .clk(clk), .reset_n(reset_n), .port_id(port_id),
    .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .rdata(rdata_q), .status(status), .addr(addr_reg), .wdata(wdata_reg),
    .irq_en(irq_en), .cmd_wr(cmd_wr), .cmd_we(cmd_we),
    .clr_done(clr_done), .clr_timeout(clr_timeout), .clr_overrun(clr_overrun)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = ddr_req;
    load_shadow = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cap_rdata   = 1'b0;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    // a CMD that cannot be accepted is lost, so flag it
    set_overrun = cmd_wr && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (cmd_wr) begin
        load_shadow = 1'b1;
        cnt_load    = 1'b1;
        req_d       = 1'b1;
        state_d     = S_REQ;
      end
      S_REQ: begin
        if (ddr_ack) begin
          req_d = 1'b0;
          if (ddr_we || ddr_rvalid) begin
            cap_rdata = !ddr_we;
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end else if (tc) begin
          req_d       = 1'b0;
          set_timeout = 1'b1;
          set_done    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (ddr_rvalid) begin
          cap_rdata = 1'b1;
          state_d   = S_DONE;
        end else if (tc) begin
          set_timeout = 1'b1;
          set_done    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        set_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ddr_req   <= 1'b0;
      ddr_we    <= 1'b0;
      ddr_addr  <= '0;
      ddr_wdata <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      state_q <= state_d;
      ddr_req <= req_d;
      if (load_shadow) begin
        ddr_we    <= cmd_we;
        ddr_addr  <= addr_reg;
        ddr_wdata <= wdata_reg;
      end
      if (cnt_load)     cnt_q <= CNT_LOAD;
      else if (cnt_dec) cnt_q <= cnt_q - CNT_W'(1);
      if (cap_rdata) rdata_q <= ddr_rdata;
      done_q    <= set_done    | (done_q    & ~clr_done);
      timeout_q <= set_timeout | (timeout_q & ~clr_timeout);
      overrun_q <= set_overrun | (overrun_q & ~clr_overrun);
      interrupt <= (set_done & ~done_q & irq_en) | (interrupt & ~interrupt_ack);
    end
  end

endmodule

// File: tb/tb_pb_ddr_mailbox.sv
// Directed bench for pb_ddr_mailbox: expected register reads and DDR requests
// are queued by the stimulus and checked by independent monitors.
module tb_pb_ddr_mailbox;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        we;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  port_id;
  logic        write_strobe, read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt, interrupt_ack;
  logic        ddr_req, ddr_we;
  logic [23:0] ddr_addr;
  logic [15:0] ddr_wdata;
  logic        ddr_ack, ddr_rvalid;
  logic [15:0] ddr_rdata;

  int tests = 0;
  int fails = 0;

  req_t        exp_req[$];
  logic [7:0]  exp_rd[$];
  logic        rd_seen = 1'b0;
  logic        req_prev = 1'b0;

  pb_ddr_mailbox #(.BASE_PORT(8'h00), .ADDR_W(24), .DATA_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset_n(reset_n), .port_id(port_id),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .ddr_req(ddr_req), .ddr_we(ddr_we),
    .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_ack(ddr_ack),
    .ddr_rdata(ddr_rdata), .ddr_rvalid(ddr_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] val);
    port_id = port; out_port = val; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] exp);
    port_id = port; read_strobe = 1'b1;
    exp_rd.push_back(exp);
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic push_req(input logic [23:0] a, input logic [15:0] d, input logic we);
    req_t r;
    r.addr = a; r.wdata = d; r.we = we;
    exp_req.push_back(r);
  endtask

  always @(posedge clk) rd_seen <= read_strobe;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 32'(in_port), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(in_port), 32'(exp_rd.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset_n && ddr_req && !req_prev) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 32'(ddr_addr), 32'hFFFF_FFFF);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        chk("req_addr", 32'(ddr_addr), 32'(r.addr));
        chk("req_wdata", 32'(ddr_wdata), 32'(r.wdata));
        chk("req_we", 32'(ddr_we), 32'(r.we));
      end
    end
    req_prev <= ddr_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; ddr_ack = 1'b0; ddr_rvalid = 1'b0;
    ddr_rdata = 16'h0000;
    cyc(3);
    chk("rst_req", 32'(ddr_req), 0);
    chk("rst_in_port", 32'(in_port), 0);
    chk("rst_irq", 32'(interrupt), 0);
    chk("rst_addr", 32'(ddr_addr), 0);
    chk("rst_wdata", 32'(ddr_wdata), 0);
    chk("rst_we", 32'(ddr_we), 0);
    reset_n = 1'b1;
    cyc(1);
    rd(8'h08, 8'h00);
    rd(8'h02, 8'h00);
    rd(8'h0F, 8'h00);

    // write access, window decode
    wr(8'h00, 8'h45);
    wr(8'h10, 8'hFF);
    rd(8'h00, 8'h45);
    rd(8'h10, 8'h00);
    wr(8'h01, 8'h23);
    wr(8'h02, 8'h01);
    wr(8'h03, 8'hEF);
    wr(8'h04, 8'hBE);
    rd(8'h02, 8'h01);
    rd(8'h04, 8'hBE);
    rd(8'h05, 8'h00);
    push_req(24'h012345, 16'hBEEF, 1'b1);
    chk("req_idle", 32'(ddr_req), 0);
    wr(8'h05, 8'h01);
    chk("req_rise", 32'(ddr_req), 1);
    cyc(2);
    ddr_ack = 1'b1; cyc(1); ddr_ack = 1'b0;
    chk("req_drop_ack", 32'(ddr_req), 0);
    cyc(1);
    rd(8'h08, 8'h02);

    // read access, rvalid five cycles after ack
    wr(8'h00, 8'h10);
    wr(8'h01, 8'h00);
    wr(8'h02, 8'h00);
    push_req(24'h000010, 16'hBEEF, 1'b0);
    wr(8'h05, 8'h00);
    chk("rd_req_rise", 32'(ddr_req), 1);
    ddr_ack = 1'b1; cyc(1); ddr_ack = 1'b0;
    chk("rd_req_drop", 32'(ddr_req), 0);
    rd(8'h08, 8'h03);
    cyc(3);
    ddr_rvalid = 1'b1; ddr_rdata = 16'hA55A;
    rd(8'h08, 8'h03);
    ddr_rvalid = 1'b0; ddr_rdata = 16'h0000;
    rd(8'h08, 8'h02);
    rd(8'h06, 8'h5A);
    rd(8'h07, 8'hA5);

    // interrupt on completion
    wr(8'h0A, 8'h02);
    rd(8'h08, 8'h00);
    wr(8'h09, 8'h01);
    rd(8'h09, 8'h01);
    wr(8'h03, 8'h34);
    wr(8'h04, 8'h12);
    push_req(24'h000010, 16'h1234, 1'b1);
    wr(8'h05, 8'h01);
    ddr_ack = 1'b1; cyc(1); ddr_ack = 1'b0;
    chk("irq_pre", 32'(interrupt), 0);
    cyc(1);
    chk("irq_set", 32'(interrupt), 1);
    wr(8'h09, 8'h00);
    chk("irq_hold_en0", 32'(interrupt), 1);
    interrupt_ack = 1'b1; cyc(1); interrupt_ack = 1'b0;
    chk("irq_ack", 32'(interrupt), 0);
    rd(8'h08, 8'h02);
    wr(8'h0A, 8'h02);
    rd(8'h08, 8'h00);

    // timeout after 15 cycles with no ack
    wr(8'h09, 8'h01);
    push_req(24'h000010, 16'h1234, 1'b0);
    wr(8'h05, 8'h00);
    cyc(14);
    chk("to_req_held", 32'(ddr_req), 1);
    cyc(1);
    chk("to_req_drop", 32'(ddr_req), 0);
    chk("to_irq", 32'(interrupt), 1);
    rd(8'h08, 8'h06);
    rd(8'h06, 8'h5A);
    ddr_ack = 1'b1; cyc(1); ddr_ack = 1'b0;
    rd(8'h08, 8'h06);
    interrupt_ack = 1'b1; cyc(1); interrupt_ack = 1'b0;
    wr(8'h0A, 8'h06);
    rd(8'h08, 8'h00);

    // overrun: second CMD while busy is dropped
    push_req(24'h000010, 16'h1234, 1'b1);
    wr(8'h05, 8'h01);
    wr(8'h00, 8'h20);
    wr(8'h05, 8'h01);
    rd(8'h08, 8'h09);
    chk("ovr_shadow_addr", 32'(ddr_addr), 32'h000010);
    ddr_ack = 1'b1; cyc(1); ddr_ack = 1'b0;
    cyc(1);
    rd(8'h08, 8'h0A);
    wr(8'h0A, 8'h08);
    rd(8'h08, 8'h02);
    rd(8'h00, 8'h20);

    // asynchronous reset during REQ
    push_req(24'h000020, 16'h1234, 1'b1);
    wr(8'h05, 8'h01);
    rd(8'h08, 8'h03);
    chk("pre_rst_req", 32'(ddr_req), 1);
    chk("pre_rst_irq", 32'(interrupt), 1);
    chk("pre_rst_in_port", 32'(in_port), 8'h03);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(ddr_req), 0);
    chk("arst_in_port", 32'(in_port), 0);
    chk("arst_irq", 32'(interrupt), 0);
    chk("arst_addr", 32'(ddr_addr), 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    rd(8'h08, 8'h00);
    rd(8'h00, 8'h00);
    rd(8'h09, 8'h00);

    // ack and rvalid in the same cycle
    wr(8'h00, 8'h20);
    push_req(24'h000020, 16'h0000, 1'b0);
    wr(8'h05, 8'h00);
    ddr_ack = 1'b1; ddr_rvalid = 1'b1; ddr_rdata = 16'h0F0E;
    cyc(1);
    ddr_ack = 1'b0; ddr_rvalid = 1'b0; ddr_rdata = 16'h0000;
    cyc(1);
    rd(8'h08, 8'h02);
    rd(8'h06, 8'h0E);
    rd(8'h07, 8'h0F);

    cyc(3);
    chk("req_queue_empty", 32'(exp_req.size()), 0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
